// File: rtl/nv_ram_rd_pkg.sv
// Shared types and defaults for the nv_ram_rws read-stream master.
package nv_ram_rd_pkg;

  localparam int AW_DEF     = 7;
  localparam int DW_DEF     = 32;
  localparam int LW_DEF     = 8;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/nv_ram_rd_skid_fifo.sv
// Two-entry output FIFO holding {last, data}; head entry is always visible on pop_data.
module nv_ram_rd_skid_fifo
  import nv_ram_rd_pkg::*;
#(
  parameter int W = DW_DEF + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   occ
);

  localparam logic [1:0] FULL_OCC = 2'(FIFO_DEPTH);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [W-1:0] mem_d [FIFO_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q + 2'(push) - 2'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign occ      = occ_q;

  // The issue throttle upstream must make these unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && occ_q == FULL_OCC));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && occ_q == 2'd0));

endmodule

// File: rtl/nv_ram_rws_rd_stream.sv
// Burst read master for nv_ram_rws RAMs, streaming words out on valid/ready.
// Optional stall counter output enabled by NV_RAM_RWS_RD_STREAM_PERF_EN.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a burst command
// RUN   | issuing RAM reads while words remain and FIFO has room
// DRAIN | all reads issued, waiting for the last word to be popped
module nv_ram_rws_rd_stream
  import nv_ram_rd_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic [AW-1:0] ra,
  output logic          re,
  input  logic [DW-1:0] dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
`ifdef NV_RAM_RWS_RD_STREAM_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt
`endif
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          inflight_q, inflight_d;
  logic          infl_last_q, infl_last_d;

  logic [1:0]    fifo_occ;
  logic [DW:0]   fifo_head;
  logic          pop;
  logic          issue;
  logic          cmd_accept;
  logic [2:0]    budget;

  nv_ram_rd_skid_fifo #(.W(DW + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({infl_last_q, dout}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .occ       (fifo_occ)
  );

  assign out_valid = (fifo_occ != 2'd0);
  assign out_data  = fifo_head[DW-1:0];
  assign out_last  = fifo_head[DW];
  assign pop       = out_valid && out_ready;

  // Slots committed for next cycle: words held, plus the read landing now, minus the pop.
  assign budget = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = (state_q == RUN) && (rem_q != '0) && (budget < 3'd2);

  assign re         = issue;
  assign ra         = addr_q;
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    inflight_d  = issue;
    infl_last_d = issue && (rem_q == LW'(1));
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          if (cmd_len != '0) state_d = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - LW'(1);
          if (rem_q == LW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
    end
  end

`ifdef NV_RAM_RWS_RD_STREAM_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (cmd_accept) begin
      perf_d = '0;
    end else if (out_valid && !out_ready && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_nv_ram_rws_rd_stream.sv
// Scoreboard bench for nv_ram_rws_rd_stream with a behavioural registered-read RAM.
module tb_nv_ram_rws_rd_stream;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [AW-1:0] ra;
  logic          re;
  logic [DW-1:0] dout = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
`ifdef NV_RAM_RWS_RD_STREAM_PERF_EN
  logic [31:0]   perf_stall_cnt;
`endif

  nv_ram_rws_rd_stream #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ra        (ra),
    .re        (re),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef NV_RAM_RWS_RD_STREAM_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) if (re) dout <= mem[ra];

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] exp_ra [$];
  logic [DW:0]   exp_out [$];

  int          occ_m = 0;
  int          infl_m = 0;
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_word = '0;

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] ad);
    return {25'b0, ad} * 32'h0101_0101;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks RAM addresses and output words against the queues, plus handshake rules.
  always @(negedge clk) begin
    int  occ_next;
    logic p;
    if (rst) begin
      exp_ra.delete();
      exp_out.delete();
      occ_m      = 0;
      infl_m     = 0;
      prev_stall = 1'b0;
    end else begin
      if (re) begin
        if (exp_ra.size() == 0) chk("unexpected_re", 1, 0);
        else chk("ra", 64'(ra), 64'(exp_ra.pop_front()));
      end
      chk("valid_vs_occ", 64'(out_valid), 64'(occ_m != 0));
      if (prev_stall) begin
        chk("stall_valid_hold", 64'(out_valid), 1);
        chk("stall_word_hold", 64'({out_last, out_data}), 64'(prev_word));
      end
      p = out_valid && out_ready;
      if (p) begin
        if (exp_out.size() == 0) chk("unexpected_out", 1, 0);
        else chk("out_word", 64'({out_last, out_data}), 64'(exp_out.pop_front()));
      end
      occ_next = occ_m + infl_m - (p ? 1 : 0);
      if (re) chk("issue_limit", 64'(occ_next + 1 <= 2), 1);
      occ_m      = occ_next;
      infl_m     = re ? 1 : 0;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  task automatic issue_cmd(input logic [AW-1:0] a, input logic [LW-1:0] n);
    int w = 0;
    logic [AW-1:0] ad;
    while (!cmd_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    for (int i = 0; i < int'(n); i++) begin
      ad = a + AW'(i);
      exp_ra.push_back(ad);
      exp_out.push_back({(i == int'(n) - 1), exp_word(ad)});
    end
    cmd_addr  = a;
    cmd_len   = n;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    while ((exp_out.size() != 0 || busy) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    chk(name, 64'((w < 500) && (exp_ra.size() == 0)), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pat [4] = '{1, 0, 0, 1};
    int w;
    for (int i = 0; i < 2**AW; i++) mem[i] = exp_word(AW'(i));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_cmd_ready", 64'(cmd_ready), 1);
    chk("rst_re", 64'(re), 0);
    chk("rst_ra", 64'(ra), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_last", 64'(out_last), 0);
    chk("rst_busy", 64'(busy), 0);
    @(posedge clk); #1;

    // Basic burst with cycle-exact timing
    issue_cmd(7'h10, 8'd4);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("basic_re_c%0d", k), 64'(re), 64'(k <= 4));
      chk($sformatf("basic_valid_c%0d", k), 64'(out_valid), 64'(k >= 3 && k <= 6));
      chk($sformatf("basic_last_c%0d", k), 64'(out_last && out_valid), 64'(k == 6));
      chk($sformatf("basic_busy_c%0d", k), 64'(busy), 64'(k <= 6));
      if (k >= 3 && k <= 6)
        chk($sformatf("basic_data_c%0d", k), 64'(out_data), 64'(32'h1010_1010 + (k - 3) * 32'h0101_0101));
      @(posedge clk); #1;
    end
    wait_drain("basic_drain");

    // Address wrap
    issue_cmd(7'h7E, 8'd4);
    wait_drain("wrap_drain");

    // Backpressure with ready pattern 1,0,0,1
    issue_cmd(7'h40, 8'd8);
    w = 0;
    while ((exp_out.size() != 0 || busy) && w < 500) begin
      out_ready = pat[w % 4][0];
      @(posedge clk); #1;
      w++;
    end
    out_ready = 1'b1;
    chk("bp_drain", 64'((w < 500) && (exp_ra.size() == 0)), 1);

    // Zero length command
    chk("zero_ready_before", 64'(cmd_ready), 1);
    issue_cmd(7'h05, 8'd0);
    for (int k = 0; k < 4; k++) begin
      chk("zero_re", 64'(re), 0);
      chk("zero_valid", 64'(out_valid), 0);
      chk("zero_ready", 64'(cmd_ready), 1);
      @(posedge clk); #1;
    end

    // Reset mid-burst with a read in flight
    issue_cmd(7'h00, 8'd16);
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst_re_before", 64'(re), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_re", 64'(re), 0);
    chk("midrst_ready", 64'(cmd_ready), 1);
    chk("midrst_busy", 64'(busy), 0);
    issue_cmd(7'h20, 8'd2);
    wait_drain("midrst_drain");
    repeat (4) begin @(posedge clk); #1; end

`ifdef NV_RAM_RWS_RD_STREAM_PERF_EN
    out_ready = 1'b0;
    issue_cmd(7'h30, 8'd2);
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("perf_first_valid", 64'(out_valid), 1);
    repeat (5) begin @(posedge clk); #1; end
    chk("perf_cnt5", 64'(perf_stall_cnt), 5);
    out_ready = 1'b1;
    wait_drain("perf_drain");
    chk("perf_hold", 64'(perf_stall_cnt), 5);
    issue_cmd(7'h00, 8'd0);
    chk("perf_clear", 64'(perf_stall_cnt), 0);
`endif

    repeat (3) begin @(posedge clk); #1; end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
